// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sequencing controller.
// State encodings double as the debug value on the `state` port.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      RUN   = 2'd3
   } state_t;

   localparam int DEF_NTAPS = 4;
   localparam int DEF_DW    = 6;

   // Tap address width; a single-tap filter still gets a 1-bit address.
   function automatic int addr_w(input int ntaps);
      return (ntaps > 1) ? $clog2(ntaps) : 1;
   endfunction

endpackage

// File: rtl/fir_pin_sync.sv
// Two-flop synchronizer for a bundle of host pins, with a history flop on bit 0
// (the strobe) so that each rising strobe produces one single-cycle event.
module fir_pin_sync #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] pins,
   output logic [W-2:0] payload,
   output logic         evt
);

   logic [W-1:0] sync_p1;
   logic [W-1:0] sync_p2;
   logic         hist_p3;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p1 <= '0;
         sync_p2 <= '0;
         hist_p3 <= 1'b0;
      end else begin
         sync_p1 <= pins;
         sync_p2 <= sync_p1;
         hist_p3 <= sync_p2[0];
      end
   end

   // Payload is taken from the same stage as the detected edge.
   assign evt     = sync_p2[0] & ~hist_p3;
   assign payload = sync_p2[W-1:1];

endmodule

// File: rtl/fir_ctrl.sv
// Host-pin sequencer for the FIR core: coefficient load ordering, post-load
// delay-line flush, one-deep pending sample, and sticky protocol/overrun flags.
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int NTAPS = DEF_NTAPS,
   parameter int DW    = DEF_DW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DW-1:0]            host_data,
   input  logic                     host_stb,
   input  logic                     host_mode,
   output logic [DW-1:0]            x_n,
   output logic                     x_valid,
   output logic                     coeff_we,
   output logic [addr_w(NTAPS)-1:0] coeff_addr,
   output logic [DW-1:0]            coeff_data,
   output logic                     loaded,
   output logic                     proto_err,
   output logic                     overrun,
   output logic [1:0]               state
);

   localparam int AW = addr_w(NTAPS);
   localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   state_t          fsm_state;
   state_t          fsm_next;
   logic [AW-1:0]   addr;
   logic [AW-1:0]   addr_next;
   logic [AW-1:0]   fcnt;
   logic [AW-1:0]   fcnt_next;
   logic            pend_vld;
   logic            pend_vld_next;
   logic [DW-1:0]   pend_data;
   logic [DW-1:0]   pend_data_next;
   logic            loaded_next;
   logic            proto_next;
   logic            over_next;
   logic [DW-1:0]   x_n_next;
   logic            x_valid_next;
   logic            coeff_we_next;
   logic [AW-1:0]   coeff_addr_next;
   logic [DW-1:0]   coeff_data_next;

   logic            evt;
   logic [DW:0]     evt_payload;
   logic            evt_mode;
   logic [DW-1:0]   evt_data;
   logic            coeff_evt;
   logic            sample_evt;

   fir_pin_sync #(
      .W (DW + 2)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .pins    ({host_mode, host_data, host_stb}),
      .payload (evt_payload),
      .evt     (evt)
   );

   assign evt_mode   = evt_payload[DW];
   assign evt_data   = evt_payload[DW-1:0];
   assign coeff_evt  = evt & evt_mode;
   assign sample_evt = evt & ~evt_mode;

   always_comb begin
      fsm_next        = fsm_state;
      addr_next       = addr;
      fcnt_next       = fcnt;
      pend_vld_next   = pend_vld;
      pend_data_next  = pend_data;
      loaded_next     = loaded;
      proto_next      = proto_err;
      over_next       = overrun;
      x_n_next        = x_n;
      x_valid_next    = 1'b0;
      coeff_we_next   = 1'b0;
      coeff_addr_next = coeff_addr;
      coeff_data_next = coeff_data;

      // Outside LOAD a coefficient always restarts programming at tap 0.
      if (coeff_evt && fsm_state != LOAD) begin
         coeff_we_next   = 1'b1;
         coeff_addr_next = '0;
         coeff_data_next = evt_data;
         loaded_next     = 1'b0;
         pend_vld_next   = 1'b0;
         addr_next       = ONE;
         fcnt_next       = '0;
         fsm_next        = (NTAPS == 1) ? FLUSH : LOAD;
      end else begin
         case (fsm_state)
            LOAD: begin
               if (coeff_evt) begin
                  coeff_we_next   = 1'b1;
                  coeff_addr_next = addr;
                  coeff_data_next = evt_data;
                  if (addr == LAST) begin
                     fsm_next  = FLUSH;
                     fcnt_next = '0;
                  end else begin
                     addr_next = addr + ONE;
                  end
               end else if (sample_evt) begin
                  proto_next = 1'b1;
               end
            end
            FLUSH: begin
               x_valid_next = 1'b1;
               x_n_next     = '0;
               if (fcnt == LAST) begin
                  fsm_next    = RUN;
                  loaded_next = 1'b1;
               end else begin
                  fcnt_next = fcnt + ONE;
               end
               if (sample_evt) begin
                  if (pend_vld) begin
                     over_next = 1'b1;
                  end else begin
                     pend_vld_next  = 1'b1;
                     pend_data_next = evt_data;
                  end
               end
            end
            RUN: begin
               // A sample colliding with the pending issue slot slips one cycle.
               if (pend_vld) begin
                  x_valid_next   = 1'b1;
                  x_n_next       = pend_data;
                  pend_vld_next  = sample_evt;
                  pend_data_next = sample_evt ? evt_data : pend_data;
               end else if (sample_evt) begin
                  x_valid_next = 1'b1;
                  x_n_next     = evt_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_state  <= IDLE;
         addr       <= '0;
         fcnt       <= '0;
         pend_vld   <= 1'b0;
         pend_data  <= '0;
         loaded     <= 1'b0;
         proto_err  <= 1'b0;
         overrun    <= 1'b0;
         x_n        <= '0;
         x_valid    <= 1'b0;
         coeff_we   <= 1'b0;
         coeff_addr <= '0;
         coeff_data <= '0;
      end else begin
         fsm_state  <= fsm_next;
         addr       <= addr_next;
         fcnt       <= fcnt_next;
         pend_vld   <= pend_vld_next;
         pend_data  <= pend_data_next;
         loaded     <= loaded_next;
         proto_err  <= proto_next;
         overrun    <= over_next;
         x_n        <= x_n_next;
         x_valid    <= x_valid_next;
         coeff_we   <= coeff_we_next;
         coeff_addr <= coeff_addr_next;
         coeff_data <= coeff_data_next;
      end
   end

   assign state = fsm_state;

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: host events are mirrored into an event-level model that
// predicts every coefficient write and sample pulse together with its clock edge.
module tb_fir_ctrl;

   localparam int NTAPS = 4;
   localparam int DW    = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] host_data;
   logic          host_stb;
   logic          host_mode;
   logic [DW-1:0] x_n;
   logic          x_valid;
   logic          coeff_we;
   logic [1:0]    coeff_addr;
   logic [DW-1:0] coeff_data;
   logic          loaded;
   logic          proto_err;
   logic          overrun;
   logic [1:0]    state;

   fir_ctrl #(.NTAPS(NTAPS), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .host_data  (host_data),
      .host_stb   (host_stb),
      .host_mode  (host_mode),
      .x_n        (x_n),
      .x_valid    (x_valid),
      .coeff_we   (coeff_we),
      .coeff_addr (coeff_addr),
      .coeff_data (coeff_data),
      .loaded     (loaded),
      .proto_err  (proto_err),
      .overrun    (overrun),
      .state      (state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int edge_cnt = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int edge_n;
      int addr;
      int data;
   } pulse_t;

   pulse_t obs_c[$];
   pulse_t obs_x[$];
   pulse_t exp_c[$];
   pulse_t exp_x[$];

   // Pulses are logged with the number of the edge that launched them.
   always @(negedge clk) begin
      if (!reset) begin
         if (coeff_we) obs_c.push_back('{edge_cnt, int'(coeff_addr), int'(coeff_data)});
         if (x_valid)  obs_x.push_back('{edge_cnt, 0, int'(x_n)});
      end
   end

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_LOAD, M_FLUSH, M_RUN} mphase_t;
   mphase_t m_ph;
   int      m_next;
   int      m_flush_last;
   int      m_pend_edge;
   bit      m_pend;
   bit      m_loaded;
   bit      m_proto;
   bit      m_over;

   task automatic model_reset();
      m_ph = M_IDLE; m_next = 0; m_flush_last = -1; m_pend_edge = -1;
      m_pend = 0; m_loaded = 0; m_proto = 0; m_over = 0;
      exp_c.delete(); exp_x.delete(); obs_c.delete(); obs_x.delete();
   endtask

   task automatic clear_queues();
      exp_c.delete(); exp_x.delete(); obs_c.delete(); obs_x.delete();
   endtask

   task automatic drop_x_from(int e);
      for (int i = exp_x.size() - 1; i >= 0; i--)
         if (exp_x[i].edge_n >= e) exp_x.delete(i);
   endtask

   task automatic start_flush(int e);
      m_ph = M_FLUSH; m_flush_last = e + NTAPS; m_pend = 0; m_pend_edge = -1;
      for (int i = 1; i <= NTAPS; i++) exp_x.push_back('{e + i, 0, 0});
   endtask

   task automatic model_settle(int now);
      if (m_ph == M_FLUSH && now > m_flush_last) begin
         m_ph = M_RUN; m_loaded = 1;
      end
   endtask

   // e: edge at which the controller acts on the event
   task automatic model_evt(bit mode, int d, int e);
      model_settle(e);
      if (mode) begin
         if (m_ph == M_LOAD) begin
            exp_c.push_back('{e, m_next, d});
            m_next++;
            if (m_next == NTAPS) start_flush(e);
         end else begin
            drop_x_from(e);
            m_pend = 0; m_pend_edge = -1; m_loaded = 0;
            exp_c.push_back('{e, 0, d});
            m_next = 1;
            if (NTAPS == 1) start_flush(e); else m_ph = M_LOAD;
         end
      end else begin
         case (m_ph)
            M_LOAD:  m_proto = 1;
            M_FLUSH: begin
               if (m_pend) m_over = 1;
               else begin
                  m_pend = 1; m_pend_edge = m_flush_last + 1;
                  exp_x.push_back('{m_pend_edge, 0, d});
               end
            end
            M_RUN:   exp_x.push_back('{(m_pend_edge == e) ? e + 1 : e, 0, d});
            default: ;
         endcase
      end
   endtask

   function automatic string fmt_q(pulse_t q[$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf("%0d:%0d=%0d ", q[i].edge_n, q[i].addr, q[i].data)};
      return s;
   endfunction

   // ---------------- stimulus ----------------
   // Called at a falling edge; data changes together with the previous strobe fall.
   task automatic send(bit mode, int d, int lo, int hi);
      host_mode = mode;
      host_data = DW'(d);
      repeat (lo) @(negedge clk);
      host_stb = 1'b1;
      model_evt(mode, d, edge_cnt + 3);
      repeat (hi) @(negedge clk);
      host_stb = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1; host_stb = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      reset = 1'b0;
   endtask

   task automatic settle();
      repeat (14) @(negedge clk);
      model_settle(edge_cnt);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; host_stb = 1'b1; host_mode = 1'b1; host_data = 6'd17;
      repeat (3) @(negedge clk);
      n_cmp += 9;
      if (state !== 2'd0)       begin n_bad++; $display("FAIL rst_state got %0d want 0", state); end
      if (x_n !== '0)           begin n_bad++; $display("FAIL rst_x_n got %0d want 0", x_n); end
      if (x_valid !== 1'b0)     begin n_bad++; $display("FAIL rst_x_valid got %b want 0", x_valid); end
      if (coeff_we !== 1'b0)    begin n_bad++; $display("FAIL rst_coeff_we got %b want 0", coeff_we); end
      if (coeff_addr !== '0)    begin n_bad++; $display("FAIL rst_coeff_addr got %0d want 0", coeff_addr); end
      if (coeff_data !== '0)    begin n_bad++; $display("FAIL rst_coeff_data got %0d want 0", coeff_data); end
      if (loaded !== 1'b0)      begin n_bad++; $display("FAIL rst_loaded got %b want 0", loaded); end
      if (proto_err !== 1'b0)   begin n_bad++; $display("FAIL rst_proto_err got %b want 0", proto_err); end
      if (overrun !== 1'b0)     begin n_bad++; $display("FAIL rst_overrun got %b want 0", overrun); end
      // strobe held high through reset must give exactly one event
      model_reset();
      reset = 1'b0;
      model_evt(1'b1, 17, edge_cnt + 3);
      repeat (4) @(negedge clk);
      host_stb = 1'b0;
      settle();
      n_cmp += 3;
      if (fmt_q(obs_c) != fmt_q(exp_c)) begin n_bad++; $display("FAIL held_stb_coeff got [%s] want [%s]", fmt_q(obs_c), fmt_q(exp_c)); end
      if (fmt_q(obs_x) != fmt_q(exp_x)) begin n_bad++; $display("FAIL held_stb_x got [%s] want [%s]", fmt_q(obs_x), fmt_q(exp_x)); end
      if (state !== 2'd1) begin n_bad++; $display("FAIL held_stb_state got %0d want 1", state); end
      clear_queues();
   endtask

   task automatic test_load_flush();
      apply_reset();
      send(1, 5, 2, 2); send(1, 12, 2, 2); send(1, 63, 2, 2); send(1, 1, 2, 2);
      settle();
      n_cmp += 4;
      if (fmt_q(obs_c) != fmt_q(exp_c)) begin n_bad++; $display("FAIL load_coeff got [%s] want [%s]", fmt_q(obs_c), fmt_q(exp_c)); end
      if (fmt_q(obs_x) != fmt_q(exp_x)) begin n_bad++; $display("FAIL load_flush got [%s] want [%s]", fmt_q(obs_x), fmt_q(exp_x)); end
      if (loaded !== 1'b1) begin n_bad++; $display("FAIL load_loaded got %b want 1", loaded); end
      if (state !== 2'd3)  begin n_bad++; $display("FAIL load_state got %0d want 3", state); end
      clear_queues();
   endtask

   task automatic test_run_samples();
      send(0, 7, 2, 2); send(0, 40, 2, 2);
      settle();
      n_cmp += 2;
      if (fmt_q(obs_x) != fmt_q(exp_x)) begin n_bad++; $display("FAIL run_samples got [%s] want [%s]", fmt_q(obs_x), fmt_q(exp_x)); end
      if (obs_c.size() !== 0) begin n_bad++; $display("FAIL run_no_coeff got %0d writes want 0", obs_c.size()); end
      clear_queues();
   endtask

   task automatic test_flush_pending();
      apply_reset();
      send(1, 3, 2, 2); send(1, 4, 2, 2); send(1, 5, 2, 2); send(1, 6, 2, 2);
      send(0, 9, 2, 2);
      settle();
      n_cmp += 3;
      if (fmt_q(obs_x) != fmt_q(exp_x)) begin n_bad++; $display("FAIL pend_x got [%s] want [%s]", fmt_q(obs_x), fmt_q(exp_x)); end
      if (overrun !== 1'b0) begin n_bad++; $display("FAIL pend_overrun got %b want 0", overrun); end
      if (loaded !== 1'b1)  begin n_bad++; $display("FAIL pend_loaded got %b want 1", loaded); end
      clear_queues();
   endtask

   task automatic test_overrun();
      apply_reset();
      send(1, 11, 2, 2); send(1, 12, 2, 2); send(1, 13, 2, 2); send(1, 14, 2, 1);
      send(0, 9, 1, 1); send(0, 10, 1, 1);
      settle();
      n_cmp += 3;
      if (fmt_q(obs_x) != fmt_q(exp_x)) begin n_bad++; $display("FAIL ovr_x got [%s] want [%s]", fmt_q(obs_x), fmt_q(exp_x)); end
      if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", overrun); end
      if (m_over !== 1'b1)  begin n_bad++; $display("FAIL ovr_timing stimulus missed flush window"); end
      clear_queues();
   endtask

   task automatic test_protocol();
      apply_reset();
      send(1, 1, 2, 2); send(1, 2, 2, 2); send(0, 22, 2, 2); send(1, 3, 2, 2); send(1, 4, 2, 2);
      settle();
      n_cmp += 4;
      if (fmt_q(obs_c) != fmt_q(exp_c)) begin n_bad++; $display("FAIL proto_coeff got [%s] want [%s]", fmt_q(obs_c), fmt_q(exp_c)); end
      if (fmt_q(obs_x) != fmt_q(exp_x)) begin n_bad++; $display("FAIL proto_x got [%s] want [%s]", fmt_q(obs_x), fmt_q(exp_x)); end
      if (proto_err !== 1'b1) begin n_bad++; $display("FAIL proto_flag got %b want 1", proto_err); end
      if (loaded !== 1'b1)    begin n_bad++; $display("FAIL proto_loaded got %b want 1", loaded); end
      clear_queues();
   endtask

   task automatic test_abort();
      apply_reset();
      send(1, 21, 2, 2); send(1, 22, 2, 2); send(1, 23, 2, 2); send(1, 24, 2, 1);
      send(1, 33, 1, 2);
      settle();
      n_cmp += 4;
      if (fmt_q(obs_c) != fmt_q(exp_c)) begin n_bad++; $display("FAIL abort_coeff got [%s] want [%s]", fmt_q(obs_c), fmt_q(exp_c)); end
      if (fmt_q(obs_x) != fmt_q(exp_x)) begin n_bad++; $display("FAIL abort_x got [%s] want [%s]", fmt_q(obs_x), fmt_q(exp_x)); end
      if (state !== 2'd1)  begin n_bad++; $display("FAIL abort_state got %0d want 1", state); end
      if (loaded !== 1'b0) begin n_bad++; $display("FAIL abort_loaded got %b want 0", loaded); end
      clear_queues();
      // reset while in LOAD
      reset = 1'b1;
      @(negedge clk);
      n_cmp += 4;
      if (state !== 2'd0)    begin n_bad++; $display("FAIL midload_state got %0d want 0", state); end
      if (coeff_addr !== '0) begin n_bad++; $display("FAIL midload_addr got %0d want 0", coeff_addr); end
      if (coeff_data !== '0) begin n_bad++; $display("FAIL midload_data got %0d want 0", coeff_data); end
      if (x_n !== '0)        begin n_bad++; $display("FAIL midload_x_n got %0d want 0", x_n); end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      int nc;
      apply_reset();
      for (int i = 0; i < 60; i++)
         send($urandom_range(0, 99) < 55, $urandom_range(0, 63), $urandom_range(1, 3), $urandom_range(1, 3));
      settle();
      n_cmp += 2;
      if (obs_c.size() !== exp_c.size()) begin n_bad++; $display("FAIL rnd_coeff_count got %0d want %0d", obs_c.size(), exp_c.size()); end
      if (obs_x.size() !== exp_x.size()) begin n_bad++; $display("FAIL rnd_x_count got %0d want %0d", obs_x.size(), exp_x.size()); end
      nc = (obs_c.size() < exp_c.size()) ? obs_c.size() : exp_c.size();
      for (int i = 0; i < nc; i++) begin
         n_cmp++;
         if (obs_c[i] !== exp_c[i]) begin
            n_bad++;
            $display("FAIL rnd_coeff[%0d] got %0d:%0d=%0d want %0d:%0d=%0d", i, obs_c[i].edge_n, obs_c[i].addr,
                     obs_c[i].data, exp_c[i].edge_n, exp_c[i].addr, exp_c[i].data);
         end
      end
      nc = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
      for (int i = 0; i < nc; i++) begin
         n_cmp++;
         if (obs_x[i] !== exp_x[i]) begin
            n_bad++;
            $display("FAIL rnd_x[%0d] got %0d=%0d want %0d=%0d", i, obs_x[i].edge_n, obs_x[i].data,
                     exp_x[i].edge_n, exp_x[i].data);
         end
      end
      n_cmp += 4;
      if (loaded !== m_loaded)   begin n_bad++; $display("FAIL rnd_loaded got %b want %b", loaded, m_loaded); end
      if (proto_err !== m_proto) begin n_bad++; $display("FAIL rnd_proto got %b want %b", proto_err, m_proto); end
      if (overrun !== m_over)    begin n_bad++; $display("FAIL rnd_overrun got %b want %b", overrun, m_over); end
      if (state !== 2'(int'(m_ph))) begin n_bad++; $display("FAIL rnd_state got %0d want %0d", state, int'(m_ph)); end
      clear_queues();
   endtask

   initial begin
      reset = 1'b1; host_stb = 1'b0; host_mode = 1'b0; host_data = '0;
      model_reset();
      test_reset();
      test_load_flush();
      test_run_samples();
      test_flush_pending();
      test_overrun();
      test_protocol();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
